rx_prbs_checker: RTL

- Receive-side companion to tx_top.
- Consumes symbol-rate I/Q samples (16-bit signed, as produced on sI_out/sQ_out) and hard-slices each branch to one bit.
- Self-synchronises a local PRBS9 generator per branch and counts bit errors for BER measurement.
- Sits at the end of the loopback/RX chain, after the downsampler; drives lock status and error/bit counters to debug/VIO.

---
 rtl/rx_prbs_checker.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_prbs_checker.sv
// rx_prbs_checker: self-synchronising PRBS9 (x^9+x^5+1) bit-error checker for I/Q symbols.
// Each branch is hard-sliced on its sign bit and compared against a local generator.
// The generator loads from received bits (SEARCH), is confirmed (VERIFY), then errors are
// counted while LOCKED. A lock is dropped when one monitoring window holds too many errors.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   valid_in         qualifies sI_in/sQ_in; only valid cycles advance state
//   sI_in, sQ_in     signed 16-bit symbol samples
//   clear            synchronous clear of bit_count/err_count (sync state unaffected)
//   locked           1 while in LOCKED
//   sync_state       0=SEARCH, 1=VERIFY, 2=LOCKED
//   err_flag         one-cycle pulse: the last LOCKED symbol had at least one bit error
//   bit_count        saturating count of bits checked while LOCKED (2 per symbol)
//   err_count        saturating count of bit errors while LOCKED
module rx_prbs_checker #(
    parameter int unsigned VERIFY_LEN = 32,
    parameter int unsigned WIN_LEN    = 128,
    parameter int unsigned LOSS_THR   = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic signed [15:0] sI_in,
    input  logic signed [15:0] sQ_in,
    input  logic               clear,
    output logic               locked,
    output logic [1:0]         sync_state,
    output logic               err_flag,
    output logic [CNT_W-1:0]   bit_count,
    output logic [CNT_W-1:0]   err_count
);

    localparam int unsigned VW  = (VERIFY_LEN > 1) ? $clog2(VERIFY_LEN) : 1;
    localparam int unsigned WW  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned EW  = $clog2(2 * WIN_LEN + 1);
    localparam int unsigned CW1 = CNT_W + 1;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } state_e;

    state_e           r_state, w_state_d;
    logic [8:0]       r_hi, r_hq, w_hi_d, w_hq_d;
    logic [3:0]       r_fill, w_fill_d;
    logic [VW-1:0]    r_vcnt, w_vcnt_d;
    logic [WW-1:0]    r_wcnt, w_wcnt_d;
    logic [EW-1:0]    r_werr, w_werr_d;
    logic [CNT_W-1:0] r_bit_count, r_err_count, w_bit_d, w_err_d;
    logic             r_err_flag, w_flag_d;
    logic             r_locked;

    logic          w_rx_i, w_rx_q, w_exp_i, w_exp_q, w_mis_i, w_mis_q;
    logic [1:0]    w_nerr;
    logic [EW-1:0] w_werr_sum;
    logic          w_fill_last, w_ver_last, w_win_last, w_loss;
    logic [CW1-1:0] w_bit_sum, w_err_sum;
    logic          w_unused;

    // Sign-bit slicer: negative -> 1, zero/positive -> 0.
    assign w_rx_i   = sI_in[15];
    assign w_rx_q   = sQ_in[15];
    assign w_unused = ^{sI_in[14:0], sQ_in[14:0]};

    assign w_exp_i = r_hi[8] ^ r_hi[4];
    assign w_exp_q = r_hq[8] ^ r_hq[4];
    assign w_mis_i = w_rx_i ^ w_exp_i;
    assign w_mis_q = w_rx_q ^ w_exp_q;
    assign w_nerr  = {1'b0, w_mis_i} + {1'b0, w_mis_q};

    assign w_werr_sum  = r_werr + EW'(w_nerr);
    assign w_fill_last = (r_fill == 4'd8);
    assign w_ver_last  = (r_vcnt == VW'(VERIFY_LEN - 1));
    assign w_win_last  = (r_wcnt == WW'(WIN_LEN - 1));
    assign w_loss      = w_win_last && (w_werr_sum >= EW'(LOSS_THR));

    // One extra bit catches overflow so the counters can saturate instead of wrapping.
    assign w_bit_sum = {1'b0, r_bit_count} + CW1'(2);
    assign w_err_sum = {1'b0, r_err_count} + CW1'(w_nerr);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StSearch;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        if (valid_in) begin
            case (r_state)
                StSearch: if (w_fill_last) w_state_d = StVerify;
                StVerify: begin
                    if (w_mis_i || w_mis_q) begin
                        w_state_d = StSearch;
                    end else if (w_ver_last) begin
                        w_state_d = StLocked;
                    end
                end
                StLocked: if (w_loss) w_state_d = StSearch;
                default:  w_state_d = StSearch;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        w_hi_d   = r_hi;
        w_hq_d   = r_hq;
        w_fill_d = r_fill;
        w_vcnt_d = r_vcnt;
        w_wcnt_d = r_wcnt;
        w_werr_d = r_werr;
        w_bit_d  = r_bit_count;
        w_err_d  = r_err_count;
        w_flag_d = 1'b0;
        if (valid_in) begin
            case (r_state)
                StSearch: begin
                    w_hi_d   = {r_hi[7:0], w_rx_i};
                    w_hq_d   = {r_hq[7:0], w_rx_q};
                    w_fill_d = w_fill_last ? 4'd0 : r_fill + 4'd1;
                    w_vcnt_d = '0;
                end
                StVerify: begin
                    // Generator free-runs on its own prediction once loaded.
                    w_hi_d = {r_hi[7:0], w_exp_i};
                    w_hq_d = {r_hq[7:0], w_exp_q};
                    if (w_mis_i || w_mis_q) begin
                        w_fill_d = 4'd0;
                    end else if (w_ver_last) begin
                        w_vcnt_d = '0;
                        w_wcnt_d = '0;
                        w_werr_d = '0;
                    end else begin
                        w_vcnt_d = r_vcnt + VW'(1);
                    end
                end
                StLocked: begin
                    w_hi_d   = {r_hi[7:0], w_exp_i};
                    w_hq_d   = {r_hq[7:0], w_exp_q};
                    w_flag_d = w_mis_i | w_mis_q;
                    w_bit_d  = w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
                    w_err_d  = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
                    if (w_win_last) begin
                        w_wcnt_d = '0;
                        w_werr_d = '0;
                        if (w_loss) w_fill_d = 4'd0;
                    end else begin
                        w_wcnt_d = r_wcnt + WW'(1);
                        w_werr_d = w_werr_sum;
                    end
                end
                default: w_fill_d = 4'd0;
            endcase
        end
        if (clear) begin
            w_bit_d = '0;
            w_err_d = '0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi        <= '0;
            r_hq        <= '0;
            r_fill      <= '0;
            r_vcnt      <= '0;
            r_wcnt      <= '0;
            r_werr      <= '0;
            r_bit_count <= '0;
            r_err_count <= '0;
            r_err_flag  <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_hi        <= w_hi_d;
            r_hq        <= w_hq_d;
            r_fill      <= w_fill_d;
            r_vcnt      <= w_vcnt_d;
            r_wcnt      <= w_wcnt_d;
            r_werr      <= w_werr_d;
            r_bit_count <= w_bit_d;
            r_err_count <= w_err_d;
            r_err_flag  <= w_flag_d;
            r_locked    <= (w_state_d == StLocked);
        end
    end

    assign locked     = r_locked;
    assign sync_state = r_state;
    assign err_flag   = r_err_flag;
    assign bit_count  = r_bit_count;
    assign err_count  = r_err_count;

endmodule
